// File: rtl/axi4s_img_frame_normalizer.sv
// axi4s_img_frame_normalizer: forces each camera frame to exactly param_width x param_height, padding or dropping pixels and pulsing one error per geometry violation
module axi4s_img_frame_normalizer #(
  parameter int DATA_BITS = 10,
  parameter int WIDTH_BITS = 16,
  parameter int HEIGHT_BITS = 16,
  parameter logic [DATA_BITS-1:0] PAD_DATA = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_BITS-1:0]  param_width,
  input  logic [HEIGHT_BITS-1:0] param_height,
  input  logic                   s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [DATA_BITS-1:0]   s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic                   m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [DATA_BITS-1:0]   m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready,
  output logic [31:0]            frame_count,
  output logic                   err_short_line,
  output logic                   err_long_line,
  output logic                   err_short_frame,
  output logic                   err_long_frame
);
  typedef enum logic [2:0] {WAIT_SOF, PASS, PAD_LINE, SKIP_LINE, PAD_FRAME} state_t;
  state_t state;
  logic [WIDTH_BITS-1:0] x, w, w_eff, cur_x;
  logic [HEIGHT_BITS-1:0] y, h, h_eff, cur_y;
  logic armed, out_free, early_sof, s_fire, fwd, pad, emit, at_eol, at_eof;
  assign out_free = !m_axi4s_tvalid || m_axi4s_tready;
  // A new SOF mid-frame is held off so it can start the next frame after padding
  assign early_sof = (state == PASS || state == SKIP_LINE) && s_axi4s_tvalid && s_axi4s_tuser;
  assign s_axi4s_tready = !reset && out_free &&
                          (state == WAIT_SOF || ((state == PASS || state == SKIP_LINE) && !early_sof));
  assign s_fire = s_axi4s_tvalid && s_axi4s_tready;
  assign fwd = s_fire && (state == PASS || (state == WAIT_SOF && s_axi4s_tuser));
  assign pad = out_free && (state == PAD_LINE || state == PAD_FRAME);
  assign emit = fwd || pad;
  // The SOF pixel uses the params directly since they latch in the same cycle
  assign w_eff = state == WAIT_SOF ? param_width : w;
  assign h_eff = state == WAIT_SOF ? param_height : h;
  assign cur_x = state == WAIT_SOF ? '0 : x;
  assign cur_y = state == WAIT_SOF ? '0 : y;
  assign at_eol = cur_x == w_eff - WIDTH_BITS'(1);
  assign at_eof = at_eol && cur_y == h_eff - HEIGHT_BITS'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_SOF;
      x <= '0;
      y <= '0;
      w <= '0;
      h <= '0;
      armed <= 1'b0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser <= 1'b0;
      m_axi4s_tlast <= 1'b0;
      m_axi4s_tdata <= '0;
      frame_count <= '0;
      {err_short_line, err_long_line, err_short_frame, err_long_frame} <= '0;
    end else begin
      {err_short_line, err_long_line, err_short_frame, err_long_frame} <= '0;
      if (state == WAIT_SOF && s_fire) begin
        if (s_axi4s_tuser) begin
          w <= param_width;
          h <= param_height;
        end
        err_long_frame <= !s_axi4s_tuser && armed;
        armed <= 1'b0;
      end
      if (out_free) m_axi4s_tvalid <= emit;
      if (emit) begin
        m_axi4s_tdata <= fwd ? s_axi4s_tdata : PAD_DATA;
        m_axi4s_tuser <= cur_x == '0 && cur_y == '0;
        m_axi4s_tlast <= at_eol;
        x <= at_eol ? '0 : cur_x + WIDTH_BITS'(1);
        y <= at_eof ? '0 : at_eol ? cur_y + HEIGHT_BITS'(1) : cur_y;
        if (at_eof) begin
          frame_count <= frame_count + 32'd1;
          armed <= 1'b1;
        end
      end
      if (early_sof) begin
        err_short_frame <= 1'b1;
        state <= PAD_FRAME;
      end else if (fwd) begin
        if (at_eof) state <= WAIT_SOF;
        else if (s_axi4s_tlast && !at_eol) begin
          err_short_line <= 1'b1;
          state <= PAD_LINE;
        end else if (!s_axi4s_tlast && at_eol) begin
          err_long_line <= 1'b1;
          state <= SKIP_LINE;
        end else state <= PASS;
      end else if (pad && (at_eof || (at_eol && state == PAD_LINE))) begin
        state <= at_eof ? WAIT_SOF : PASS;
      end else if (state == SKIP_LINE && s_fire && s_axi4s_tlast) begin
        state <= PASS;
      end
    end
  end
endmodule

// File: tb/tb_axi4s_img_frame_normalizer.sv
// tb_axi4s_img_frame_normalizer: scoreboard bench for the frame normalizer at 4x3 geometry
module tb_axi4s_img_frame_normalizer;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] param_width = 16'd4, param_height = 16'd3;
  logic s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [9:0] s_tdata = '0, m_tdata;
  logic m_tuser, m_tlast, m_tvalid, m_tready;
  logic [31:0] frame_count;
  logic e_sl, e_ll, e_sf, e_lf;
  int n_chk = 0, n_fail = 0, cyc = 0, fc_exp = 0;
  int n_sl = 0, n_ll = 0, n_sf = 0, n_lf = 0;
  int b[4];
  logic [11:0] q[$];
  logic [12:0] held;
  bit stall = 0, bp = 0;

  axi4s_img_frame_normalizer dut (
    .clk(clk), .reset(reset), .param_width(param_width), .param_height(param_height),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready), .frame_count(frame_count),
    .err_short_line(e_sl), .err_long_line(e_ll), .err_short_frame(e_sf), .err_long_frame(e_lf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (e_sl) n_sl++;
    if (e_ll) n_ll++;
    if (e_sf) n_sf++;
    if (e_lf) n_lf++;
    if (stall) chk("hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, held);
    stall = m_tvalid && !m_tready && !reset;
    held = {m_tvalid, m_tuser, m_tlast, m_tdata};
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) chk("unexpected_px", 1, 0);
      else chk("px", {m_tuser, m_tlast, m_tdata}, q.pop_front());
    end
  end

  task automatic send(input bit u, input bit l, input logic [9:0] d);
    int n = 0;
    s_tuser = u;
    s_tlast = l;
    s_tdata = d;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 300);
    if (!s_tready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic exp_px(input bit u, input bit l, input logic [9:0] d);
    q.push_back({u, l, d});
  endtask

  task automatic fwd(input bit u, input bit l, input logic [9:0] d);
    exp_px(u, l, d);
    send(u, l, d);
  endtask

  task automatic frame(input int base);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) fwd(r == 0 && c == 0, c == 3, 10'(base + r * 4 + c));
  endtask

  task automatic mark;
    b[0] = n_sl;
    b[1] = n_ll;
    b[2] = n_sf;
    b[3] = n_lf;
  endtask

  task automatic drain(input string tag, input int sl, input int ll, input int sf, input int lf);
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_frames"}, frame_count, fc_exp);
    chk({tag, "_short_line"}, n_sl - b[0], sl);
    chk({tag, "_long_line"}, n_ll - b[1], ll);
    chk({tag, "_short_frame"}, n_sf - b[2], sf);
    chk({tag, "_long_frame"}, n_lf - b[3], lf);
    mark;
  endtask

  initial begin
    int c0;
    logic [9:0] d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_out", {m_tvalid, m_tuser, m_tlast, m_tdata}, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_err", {e_sl, e_ll, e_sf, e_lf}, 0);
    reset = 1'b0;
    mark;
    for (int i = 0; i < 5; i++) send(0, i == 4, 10'(900 + i));
    drain("junk", 0, 0, 0, 0);
    c0 = cyc;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) begin
          d = 10'(100 + f * 50 + r * 4 + c);
          fwd(r == 0 && c == 0, c == 3, d);
          if (f == 0 && r == 0 && c == 0) chk("latency", {m_tvalid, m_tuser, m_tdata}, {2'b11, d});
        end
    chk("throughput", cyc - c0, 24);
    fc_exp += 2;
    drain("nominal", 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) fwd(c == 0, c == 3, 10'(300 + c));
    fwd(0, 0, 10'd310);
    exp_px(0, 0, 10'd311);
    send(0, 1, 10'd311);
    exp_px(0, 0, 10'd0);
    exp_px(0, 1, 10'd0);
    for (int c = 0; c < 4; c++) fwd(0, c == 3, 10'(320 + c));
    fc_exp++;
    drain("short_line", 1, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) exp_px(c == 0, c == 3, 10'(400 + c));
      send(c == 0, c == 5, 10'(400 + c));
    end
    for (int c = 0; c < 8; c++) fwd(0, c % 4 == 3, 10'(410 + c));
    fc_exp++;
    drain("long_line", 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) fwd(c == 0, c == 3, 10'(500 + c));
    fwd(0, 0, 10'd510);
    fwd(0, 0, 10'd511);
    for (int i = 0; i < 6; i++) exp_px(0, i == 1 || i == 5, 10'd0);
    frame(520);
    fc_exp += 2;
    drain("early_sof", 0, 0, 1, 0);
    frame(600);
    for (int i = 0; i < 3; i++) send(0, i == 2, 10'(650 + i));
    fc_exp++;
    drain("long_frame", 0, 0, 0, 1);
    bp = 1;
    frame(700);
    frame(750);
    fc_exp += 2;
    drain("backpressure", 0, 0, 0, 0);
    bp = 0;
    @(posedge clk);
    #1;
    fwd(1, 0, 10'd800);
    fwd(0, 0, 10'd801);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tready", s_tready, 0);
    chk("mid_rst_out", {m_tvalid, m_tuser, m_tlast, m_tdata}, 0);
    chk("mid_rst_frames", frame_count, 0);
    chk("mid_rst_err", {e_sl, e_ll, e_sf, e_lf}, 0);
    reset = 1'b0;
    fc_exp = 0;
    send(0, 0, 10'd802);
    send(0, 1, 10'd803);
    frame(850);
    fc_exp++;
    drain("after_reset", 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/axi4s_img_frame_normalizer.md
# axi4s_img_frame_normalizer

Normalizes the raw 10-bit camera pixel stream to a fixed geometry before it enters image processing, sitting directly between camera receive and the optical-flow pipeline on the image stream. Drops pixels before the first start-of-frame and pads short lines and frames with a constant. Truncates long lines and frames. Every output frame is therefore exactly `param_width` x `param_height` with correct `tuser`/`tlast`, and each geometry violation is reported as a one-cycle error pulse.

## Interface
Parameters:
- `DATA_BITS`, 10, pixel width.
- `WIDTH_BITS`, 16, width of `param_width` and the column counter.
- `HEIGHT_BITS`, 16, width of `param_height` and the row counter.
- `PAD_DATA`, 0, `DATA_BITS` value emitted for padded pixels.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `param_width` in `WIDTH_BITS`: pixels per line, ≥1. Latched when a frame is accepted.
- `param_height` in `HEIGHT_BITS`: lines per frame, ≥1. Latched when a frame is accepted.
- `s_axi4s_tuser` in 1: start of frame.
- `s_axi4s_tlast` in 1: end of line.
- `s_axi4s_tdata` in `DATA_BITS`: input pixel.
- `s_axi4s_tvalid` in 1: input valid.
- `s_axi4s_tready` out 1: input ready.
- `m_axi4s_tuser` out 1: output start of frame.
- `m_axi4s_tlast` out 1: output end of line.
- `m_axi4s_tdata` out `DATA_BITS`: output pixel.
- `m_axi4s_tvalid` out 1: output valid.
- `m_axi4s_tready` in 1: output ready.
- `frame_count` out 32: number of completed output frames. Wraps modulo 2^32.
- `err_short_line` out 1: pulse when a line is padded.
- `err_long_line` out 1: pulse when a line is truncated.
- `err_short_frame` out 1: pulse when a frame is padded.
- `err_long_frame` out 1: pulse when trailing frame data is dropped.

## Operation
- Counters: `x`, `y` track the next output position. Latched `W`, `H` come from the params.
- A transfer happens when tvalid and tready are both high.
- Output pixel flags: `m_tuser` = (x==0 && y==0); `m_tlast` = (x==W-1).
- Position advance per output transfer:
  - x increments.
  - At x==W-1, x returns to 0 and y increments.
  - At x==W-1 && y==H-1, `frame_count` increments and the FSM enters WAIT_SOF.

States:
- **WAIT_SOF** (reset state). `s_tready`=1.
  - Input with tuser=1: latch W/H, x=y=0, forward the pixel, then PASS. Width 1 / height 1 frames complete immediately via the position-advance rule.
  - Input with tuser=0: dropped. The first drop after a completed frame pulses `err_long_frame` once. Drops after reset do not pulse.
- **PASS**. Input is forwarded.
  - Input tuser=1 while (x,y)≠(0,0): the pixel is not consumed. Pulse `err_short_frame`, go to PAD_FRAME.
  - Input tlast=1 with x<W-1: forward the pixel with m_tlast=0. Pulse `err_short_line`, go to PAD_LINE.
  - Input tlast=0 with x==W-1: forward with m_tlast=1. Pulse `err_long_line`, go to SKIP_LINE. If this pixel ends the frame, go to WAIT_SOF instead (the frame-end rule wins), and do not pulse `err_long_line`.
- **PAD_LINE**. `s_tready`=0. Emit `PAD_DATA` until the x==W-1 pixel is transferred, then PASS (or WAIT_SOF at frame end).
- **SKIP_LINE**. `s_tready`=1. Drop pixels through and including the one with tlast=1, then PASS.
  - Input tuser=1: do not consume. Pulse `err_short_frame`, go to PAD_FRAME.
- **PAD_FRAME**. `s_tready`=0. Emit `PAD_DATA` to the frame end, then WAIT_SOF. The pending tuser pixel is accepted there.
- Error pulses last one cycle each. Several may assert in the same cycle.
- Pixel values are never modified. Padding is only ever `PAD_DATA`.

## Timing
- The output is a single register stage. Latency from input transfer to `m_tvalid` is 1 cycle.
- In forwarding states: `s_tready` = !m_tvalid || m_tready. This is combinational and gives full throughput, one pixel per clock.
- Pad states generate one pixel per cycle whenever the output register is free.
- `m_*` holds stable while m_tvalid && !m_tready.
- Reset (any cycle, including mid-frame) forces the following state, and the next frame is accepted only at a new tuser:
  - FSM = WAIT_SOF.
  - x = y = 0.
  - `m_axi4s_tvalid`, `m_axi4s_tuser`, `m_axi4s_tlast` = 0; `m_axi4s_tdata` = 0.
  - `frame_count` = 0.
  - All err pulses = 0.
  - `s_axi4s_tready` = 0 during reset.
- Param changes mid-frame have no effect until the next accepted tuser.

## Test plan
- **Nominal:** W=4, H=3, two well-formed frames, m_tready=1 → 24 output pixels at 1/clk, latency 1. tuser on pixels 0 and 12; tlast on every 4th; `frame_count`=2; no err pulses.
- **Short line:** line 1 tlast after 2 pixels → that line emits 2 data + 2 `PAD_DATA`, tlast on the 4th. One `err_short_line` pulse; the following line is unaffected.
- **Long line:** line 0 has 6 pixels → 4 emitted with tlast, 2 dropped, one `err_long_line`. Line 1 starts with the 7th input pixel.
- **Early SOF:** new tuser after 1.5 lines → remainder padded to 12 pixels, one `err_short_frame`. The new frame starts with m_tuser=1 on the held pixel.
- **Long frame / pre-SOF junk:** 5 pixels without tuser after reset → dropped, no err. 3 extra pixels after a full frame → dropped, exactly one `err_long_frame`.
- **Backpressure & reset:** random m_tready at 50% → output identical to the nominal run. Reset asserted mid-line → all outputs at reset values; the stream resumes cleanly at the next tuser.
